// File: rtl/comparator_pkg.sv
// rtl/comparator_pkg.sv - shared types for the comparator family
package comparator_pkg;

    // Sequencing states of the bit-serial equality checker.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/comparator.sv
// rtl/comparator.sv - 1-bit equality cell
//
// Purpose : reports whether two single bits are equal.
// Ports   : i_a, i_b - bits under comparison
//           o_eq     - 1 when i_a == i_b
module comparator (
    input  logic i_a,
    input  logic i_b,
    output logic o_eq
);

    assign o_eq = ~(i_a ^ i_b);

endmodule

// File: rtl/serial_eq_comparator.sv
// rtl/serial_eq_comparator.sv - bit-serial word equality checker
//
// Purpose : consumes two WIDTH-bit words LSB-first, one bit-pair per valid
//           cycle, and reports equality plus the lowest differing bit index.
// Ports   : Clk_CI          - clock, rising edge
//           Rst_RBI         - synchronous active-low reset
//           Start_SI        - begin a comparison (accepted in IDLE or DONE)
//           BitValid_SI     - BitA_DI/BitB_DI carry a valid bit-pair
//           BitA_DI/BitB_DI - serial bits of words A and B, LSB first
//           Busy_SO         - high while shifting
//           Done_SO         - one-cycle pulse when results update
//           Equal_DO        - 1 when all bits of the last word pair matched
//           MismatchIdx_DO  - lowest differing bit index (0 when equal)
module serial_eq_comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic            Clk_CI,
    input  logic            Rst_RBI,
    input  logic            Start_SI,
    input  logic            BitValid_SI,
    input  logic            BitA_DI,
    input  logic            BitB_DI,
    output logic            Busy_SO,
    output logic            Done_SO,
    output logic            Equal_DO,
    output logic [IDXW-1:0] MismatchIdx_DO
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [IDXW-1:0] r_cnt;
    logic            r_run_eq;
    logic [IDXW-1:0] r_run_idx;
    logic            r_eq;
    logic [IDXW-1:0] r_idx;
    logic            r_busy;
    logic            r_done;

    logic            w_bit_eq;
    logic            w_start;
    logic            w_sample;
    logic            w_last;
    logic            w_eq_final;
    logic [IDXW-1:0] w_idx_final;

    comparator u_bit_cmp (
        .i_a  (BitA_DI),
        .i_b  (BitB_DI),
        .o_eq (w_bit_eq)
    );

    assign w_start  = Start_SI && ((r_state == IDLE) || (r_state == DONE));
    assign w_sample = (r_state == SHIFT) && BitValid_SI;
    assign w_last   = w_sample && (r_cnt == LAST_IDX);

    // Running values including the bit-pair being sampled this cycle; only the
    // first mismatch captures the index.
    assign w_eq_final  = r_run_eq & w_bit_eq;
    assign w_idx_final = (r_run_eq && !w_bit_eq) ? r_cnt : r_run_idx;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (Start_SI) w_state_next = SHIFT;
            SHIFT:   if (w_last)   w_state_next = DONE;
            DONE:    w_state_next = Start_SI ? SHIFT : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_run_eq  <= 1'b0;
            r_run_idx <= '0;
            r_eq      <= 1'b0;
            r_idx     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == SHIFT);
            r_done  <= w_last;
            if (w_start) begin
                r_cnt     <= '0;
                r_run_eq  <= 1'b1;
                r_run_idx <= '0;
            end else if (w_sample) begin
                r_run_eq  <= w_eq_final;
                r_run_idx <= w_idx_final;
                if (w_last) begin
                    r_eq  <= w_eq_final;
                    r_idx <= w_idx_final;
                end else begin
                    // Counter stops at WIDTH-1 so it never wraps.
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign Busy_SO        = r_busy;
    assign Done_SO        = r_done;
    assign Equal_DO       = r_eq;
    assign MismatchIdx_DO = r_idx;

endmodule

// File: doc/serial_eq_comparator.md
# serial_eq_comparator

Bit-serial equality checker: receives two WIDTH-bit words LSB-first, one bit-pair per accepted cycle, and reports whether they are equal plus the index of the first (lowest) differing bit. Sits downstream of serial links and scan paths where parallel words are not available. It is the sequential, stream-consuming counterpart of the combinational equality comparators in this library, and reuses the 1-bit equality cell internally.

## Interface
- WIDTH, 8, bits per compared word; legal range 2..256.
- IDXW, $clog2(WIDTH), derived; width of the mismatch index.
- Clk_CI  input  1  clock; all logic on its rising edge.
- Rst_RBI  input  1  reset, synchronous, active-low.
- Start_SI  input  1  begin a new comparison; honoured only in IDLE or DONE.
- BitValid_SI  input  1  BitA_DI/BitB_DI hold a valid bit-pair this cycle.
- BitA_DI  input  1  serial bit of word A, LSB first.
- BitB_DI  input  1  serial bit of word B, LSB first.
- Busy_SO  output  1  high while in SHIFT.
- Done_SO  output  1  one-cycle pulse: result registers were just updated.
- Equal_DO  output  1  result of the last completed comparison; 1 = all WIDTH bits matched.
- MismatchIdx_DO  output  IDXW  lowest differing bit index of the last comparison; 0 when Equal_DO=1.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: Start_SI=1 -> SHIFT; clear bit counter to 0, set running-equal flag to 1, clear running index. BitValid_SI ignored.
- SHIFT: each cycle with BitValid_SI=1 samples one bit-pair and advances the counter. If bits differ and running-equal is still 1: running-equal <= 0, running index <= current counter value. Later mismatches do not change the index. BitValid_SI=0 is a stall: no state change.
- SHIFT -> DONE on the cycle the bit with counter = WIDTH-1 is sampled. All WIDTH bits are always consumed; no early exit on mismatch.
- DONE lasts exactly one cycle. Equal_DO/MismatchIdx_DO load the running values on entry to DONE. Start_SI=1 in DONE -> SHIFT, back-to-back, with the same initialisation as from IDLE. Otherwise -> IDLE.
- Start_SI in SHIFT is ignored.
- Equal_DO and MismatchIdx_DO hold their value from DONE until the next DONE. They do not change during SHIFT.
- Counter width is IDXW bits and never wraps: the terminal compare at WIDTH-1 is exact.

## Timing
- Reset values: state IDLE, Busy_SO=0, Done_SO=0, Equal_DO=0, MismatchIdx_DO=0, counter=0.
- Reset asserted in any state, including mid-SHIFT: the next edge forces reset values. The partial comparison is discarded and no Done_SO is issued.
- Start_SI sampled at edge 0. The earliest bit sample is at edge 1; a bit valid together with Start is not sampled.
- With BitValid_SI held high, bits are sampled at edges 1..WIDTH. Done_SO and the result outputs are visible after edge WIDTH (registered). Total latency from Start is WIDTH+1 cycles.
- Each stall cycle adds exactly one cycle of latency.
- Busy_SO is high from the cycle after Start is accepted until the cycle DONE is entered. It is low in DONE.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package comparator_pkg holds the state enum typedef (IDLE, SHIFT, DONE) as logic [1:0].
- The existing 1-bit `comparator` cell is the single sub-module instance. Its inputs are BitA_DI and BitB_DI; its output is the per-bit match used by the running-equal update.
- One always_ff block for state, counter and running/result registers; one always_comb block for next state.

## Test plan
- Reset, then idle for 5 cycles with random BitValid_SI -> all outputs remain 0, no Done_SO.
- WIDTH=8, Start, then stream A=0xA5 and B=0xA5 continuously -> Done_SO pulses 9 cycles after Start, with Equal_DO=1 and MismatchIdx_DO=0.
- A=0x80 vs B=0x00 -> Equal_DO=0, MismatchIdx_DO=7. A=0xF0 vs B=0x0F -> MismatchIdx_DO=0, with all 8 bits still consumed.
- A=0x3C vs B=0x34, with BitValid_SI low on 3 scattered cycles -> Done_SO pulses 12 cycles after Start, with Equal_DO=0 and MismatchIdx_DO=3.
- Start pulsed again mid-SHIFT -> ignored, result unchanged. Start held in DONE -> next comparison begins with no IDLE cycle, and the previous result is held until the new Done_SO.
- Rst_RBI low for 1 cycle after 4 bits -> outputs return to reset values and no Done_SO is issued. A fresh Start with equal words -> Equal_DO=1.
